// File: rtl/decoder_input_conditioner_if.sv
// Valid/ready code channel from the input conditioner to the decoder.
// The master drives a settled code; the slave acknowledges it with code_ready.
interface decoder_input_conditioner_if #(
    parameter int unsigned WIDTH = 7
);
    logic [WIDTH-1:0] code_out;
    logic             code_valid;
    logic             code_ready;

    modport master (
        output code_out,
        output code_valid,
        input  code_ready
    );

    modport slave (
        input  code_out,
        input  code_valid,
        output code_ready
    );
endinterface

// File: rtl/decoder_input_conditioner.sv
// Synchronises and debounces raw pad inputs and hands each newly settled code to the decoder
// through a single-entry valid/ready slot, flagging codes that overwrite an undelivered one.
module decoder_input_conditioner #(
    parameter int unsigned WIDTH           = 7,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [WIDTH-1:0]             pins_in,
    decoder_input_conditioner_if.master  dec,
    output logic                         overrun,
    input  logic                         clear_overrun,
    output logic                         busy
);
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {StIdle, StSettle} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sync1_q, sync2_q;
    logic [WIDTH-1:0]  stable_q, stable_d;
    logic [WIDTH-1:0]  cand_q, cand_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  code_q, code_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              accept;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            cand_q    <= '0;
            cnt_q     <= '0;
            state_q   <= StIdle;
            code_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync1_q   <= pins_in;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // Debounce FSM: only sync2 is observed, priority order matters in StSettle.
    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sync2_q != stable_q) begin
                    state_d = StSettle;
                    cand_d  = sync2_q;
                    cnt_d   = CntOne;
                end
            end
            StSettle: begin
                if (sync2_q == stable_q) begin
                    state_d = StIdle;
                end else if (sync2_q != cand_q) begin
                    cand_d = sync2_q;
                    cnt_d  = CntOne;
                end else if (cnt_q < CntLast) begin
                    cnt_d = cnt_q + CntOne;
                end else begin
                    accept   = 1'b1;
                    stable_d = cand_q;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output slot: a new code always wins; it only counts as overrun if the old one was stuck.
    always_comb begin
        code_d    = code_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (valid_q && dec.code_ready) begin
            valid_d = 1'b0;
        end
        if (clear_overrun) begin
            overrun_d = 1'b0;
        end
        if (accept) begin
            code_d  = cand_q;
            valid_d = 1'b1;
            if (valid_q && !dec.code_ready) begin
                overrun_d = 1'b1;
            end
        end
    end

    assign dec.code_out   = code_q;
    assign dec.code_valid = valid_q;
    assign overrun        = overrun_q;
    assign busy           = (state_q == StSettle);
endmodule

// File: tb/tb_decoder_input_conditioner.sv
// Self-checking bench for decoder_input_conditioner: cycle table, corner-case sequences and
// randomized pin activity against a run-length reference model.
module tb_decoder_input_conditioner;
    localparam int unsigned W = 7;
    localparam int unsigned D = 4;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] pins_in = '0;
    logic         clear_overrun = 1'b0;
    logic         overrun;
    logic         busy;

    decoder_input_conditioner_if #(.WIDTH(W)) dec_if ();

    decoder_input_conditioner #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .pins_in       (pins_in),
        .dec           (dec_if),
        .overrun       (overrun),
        .clear_overrun (clear_overrun),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: sync chain as a 2-deep delay, debounce as run length of the synced value.
    logic [W-1:0] m_s1, m_s2, m_stable, m_last, m_code;
    int           m_run;
    logic         m_valid, m_ov, m_busy;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_last = '0; m_code = '0;
        m_run = 0; m_valid = 1'b0; m_ov = 1'b0; m_busy = 1'b0;
    endtask

    task automatic model_edge(input logic [W-1:0] p, input logic r, input logic c);
        logic [W-1:0] s;
        logic         acc;
        logic         old_valid;
        s = m_s2;
        if (m_run > 0 && s == m_last) m_run++;
        else begin
            m_last = s;
            m_run  = 1;
        end
        acc       = (s != m_stable) && (m_run == D);
        old_valid = m_valid;
        if (old_valid && r) m_valid = 1'b0;
        if (c) m_ov = 1'b0;
        if (acc) begin
            m_code   = s;
            m_valid  = 1'b1;
            m_stable = s;
            if (old_valid && !r) m_ov = 1'b1;
        end
        m_busy = (s != m_stable);
        m_s2 = m_s1;
        m_s1 = p;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("model code_out", 32'(dec_if.code_out), 32'(m_code));
        check("model code_valid", 32'(dec_if.code_valid), 32'(m_valid));
        check("model overrun", 32'(overrun), 32'(m_ov));
        check("model busy", 32'(busy), 32'(m_busy));
    endtask

    task automatic cycle(input logic [W-1:0] p, input logic r, input logic c);
        pins_in = p;
        dec_if.code_ready = r;
        clear_overrun = c;
        @(posedge clock);
        model_edge(p, r, c);
        #1;
        check_model();
    endtask

    // Asserts reset mid-cycle, checks outputs clear without a clock, releases off-edge.
    task automatic do_reset(input logic [W-1:0] p, input logic r);
        pins_in = p;
        dec_if.code_ready = r;
        clear_overrun = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("reset code_out", 32'(dec_if.code_out), 32'h0);
        check("reset code_valid", 32'(dec_if.code_valid), 32'h0);
        check("reset overrun", 32'(overrun), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        model_reset();
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
    endtask

    typedef struct {
        logic [W-1:0] pins;
        logic         ready;
        logic         clr;
        logic         e_valid;
        logic [W-1:0] e_code;
        logic         e_ov;
        logic         e_busy;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int deliveries;
        int when;
        logic seen_busy;
        logic [W-1:0] pv;

        dec_if.code_ready = 1'b1;
        model_reset();

        // Power-up delivery, then overrun and its clear, one row per clock edge.
        vecs[0]  = '{7'h69, 1'b1, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0};
        vecs[1]  = '{7'h69, 1'b1, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0};
        vecs[2]  = '{7'h69, 1'b1, 1'b0, 1'b0, 7'h00, 1'b0, 1'b1};
        vecs[3]  = '{7'h69, 1'b1, 1'b0, 1'b0, 7'h00, 1'b0, 1'b1};
        vecs[4]  = '{7'h69, 1'b1, 1'b0, 1'b0, 7'h00, 1'b0, 1'b1};
        vecs[5]  = '{7'h69, 1'b1, 1'b0, 1'b1, 7'h69, 1'b0, 1'b0};
        vecs[6]  = '{7'h2A, 1'b0, 1'b0, 1'b1, 7'h69, 1'b0, 1'b0};
        vecs[7]  = '{7'h2A, 1'b0, 1'b0, 1'b1, 7'h69, 1'b0, 1'b0};
        vecs[8]  = '{7'h2A, 1'b0, 1'b0, 1'b1, 7'h69, 1'b0, 1'b1};
        vecs[9]  = '{7'h2A, 1'b0, 1'b0, 1'b1, 7'h69, 1'b0, 1'b1};
        vecs[10] = '{7'h2A, 1'b0, 1'b0, 1'b1, 7'h69, 1'b0, 1'b1};
        vecs[11] = '{7'h2A, 1'b0, 1'b0, 1'b1, 7'h2A, 1'b1, 1'b0};
        vecs[12] = '{7'h2A, 1'b0, 1'b1, 1'b1, 7'h2A, 1'b0, 1'b0};
        vecs[13] = '{7'h2A, 1'b1, 1'b0, 1'b0, 7'h2A, 1'b0, 1'b0};

        #3;
        do_reset(7'h69, 1'b1);
        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].pins, vecs[i].ready, vecs[i].clr);
            check($sformatf("vec%0d code_valid", i), 32'(dec_if.code_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d code_out", i), 32'(dec_if.code_out), 32'(vecs[i].e_code));
            check($sformatf("vec%0d overrun", i), 32'(overrun), 32'(vecs[i].e_ov));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
        end

        // Bounce: one delivery, timed from the last transition.
        do_reset(7'h00, 1'b1);
        repeat (3) cycle(7'h00, 1'b1, 1'b0);
        repeat (2) cycle(7'h69, 1'b1, 1'b0);
        cycle(7'h00, 1'b1, 1'b0);
        deliveries = 0;
        when = -1;
        for (int j = 0; j < 10; j++) begin
            cycle(7'h69, 1'b1, 1'b0);
            if (dec_if.code_valid) begin
                deliveries++;
                when = j;
                check("bounce code", 32'(dec_if.code_out), 32'h69);
            end
        end
        check("bounce deliveries", 32'(deliveries), 32'd1);
        check("bounce timing", 32'(when), 32'(D + 1));

        // Glitch shorter than the window: busy rises and falls, nothing delivered.
        seen_busy = 1'b0;
        deliveries = 0;
        repeat (3) cycle(7'h12, 1'b1, 1'b0);
        for (int j = 0; j < 6; j++) begin
            cycle(7'h69, 1'b1, 1'b0);
            if (busy) seen_busy = 1'b1;
            if (dec_if.code_valid) deliveries++;
        end
        check("glitch busy seen", 32'(seen_busy), 32'd1);
        check("glitch busy end", 32'(busy), 32'd0);
        check("glitch deliveries", 32'(deliveries), 32'd0);

        // Accept of 55 over pending 69 while the decoder takes 69 on the same edge.
        do_reset(7'h69, 1'b0);
        repeat (7) cycle(7'h69, 1'b0, 1'b0);
        check("simul pending", 32'(dec_if.code_valid), 32'd1);
        repeat (D + 1) cycle(7'h55, 1'b0, 1'b0);
        cycle(7'h55, 1'b1, 1'b0);
        check("simul valid", 32'(dec_if.code_valid), 32'd1);
        check("simul code", 32'(dec_if.code_out), 32'h55);
        check("simul overrun", 32'(overrun), 32'd0);

        // Reset while a code is pending and another is settling; held 69 is re-delivered.
        do_reset(7'h69, 1'b0);
        repeat (7) cycle(7'h69, 1'b0, 1'b0);
        repeat (3) cycle(7'h2A, 1'b0, 1'b0);
        check("pre-reset busy", 32'(busy), 32'd1);
        check("pre-reset valid", 32'(dec_if.code_valid), 32'd1);
        do_reset(7'h69, 1'b1);
        deliveries = 0;
        for (int j = 0; j < 12; j++) begin
            cycle(7'h69, 1'b1, 1'b0);
            if (dec_if.code_valid && dec_if.code_out == 7'h69) deliveries++;
        end
        check("re-delivery", 32'(deliveries), 32'd1);

        // Randomized pin activity with random ready and clear.
        for (int s = 0; s < 400; s++) begin
            int hold;
            case ($urandom_range(0, 5))
                0: pv = 7'h00;
                1: pv = 7'h69;
                2: pv = 7'h2A;
                3: pv = 7'h55;
                4: pv = 7'h12;
                default: pv = W'($urandom);
            endcase
            hold = $urandom_range(1, 7);
            for (int h = 0; h < hold; h++) begin
                cycle(pv, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
